hazard_stall_unit: RTL and testbench
====================================

HAZARD_STALL_UNIT -- requirements
Module: hazard_stall_unit

Interface
REQ-001 The block SHALL have these ports, one clock domain; reset is synchronous and active-high:
  clk  in  1  pipeline clock, all state on rising edge
  reset  in  1  synchronous active-high reset
  ID_Rs  in  5  Rs field of instruction in IF/ID
  ID_Rt  in  5  Rt field of instruction in IF/ID
  ID_UsesRt  in  1  IF/ID instruction reads Rt (R-type, store, beq/bne)
  ID_Branch  in  1  IF/ID instruction is beq/bne (compared in ID)
  ID_BranchTaken  in  1  ID comparator outcome, valid when ID_Branch=1
  ID_Ex_MemRead  in  1  instruction in ID/EX is a load
  ID_Ex_RegWrite  in  1  instruction in ID/EX writes a register
  ID_Ex_WriteReg  in  5  destination register of ID/EX instruction
  Ex_Mem_MemRead  in  1  instruction in EX/MEM is a load
  Ex_Mem_WriteReg  in  5  destination register of EX/MEM instruction
  PCWrite  out  1  1 = PC updates
  IF_IdWrite  out  1  1 = IF/ID register updates
  ID_ExFlush  out  1  1 = insert bubble (zero control) into ID/EX
  IF_IdFlush  out  1  1 = squash IF/ID (taken branch)
  HazardType  out  2  00 none, 01 load-use, 10 branch-ALU, 11 branch-load

Function
REQ-002 Match(r) SHALL be true when r!=0 and (r==ID_Rs or (ID_UsesRt and r==ID_Rt)); register 0 never matches.
REQ-003 Load-use hazard: ID_Ex_MemRead and Match(ID_Ex_WriteReg); stall length 1, unless REQ-005 applies.
REQ-004 Branch-ALU hazard: ID_Branch and ID_Ex_RegWrite and !ID_Ex_MemRead and Match(ID_Ex_WriteReg); length 1, HazardType=10.
REQ-005 Branch-load hazard: ID_Branch and ID_Ex_MemRead and Match(ID_Ex_WriteReg); length 2, HazardType=11; otherwise ID_Branch and Ex_Mem_MemRead and Match(Ex_Mem_WriteReg); length 1, HazardType=11.
REQ-006 Priority when several hold: branch-load length 2 > branch-load length 1 > branch-ALU > load-use.
REQ-007 FSM states: IDLE and HOLD. Detection SHALL happen only in IDLE; it is combinational (Mealy), so stall outputs assert in the detecting cycle with zero latency.
REQ-008 IDLE with hazard: PCWrite=0, IF_IdWrite=0, ID_ExFlush=1; next state HOLD if length 2, else IDLE.
REQ-009 HOLD: unconditional stall (PCWrite=0, IF_IdWrite=0, ID_ExFlush=1) with HazardType held from the entry cycle; next state IDLE; inputs are ignored.
REQ-010 No stall: PCWrite=1, IF_IdWrite=1, ID_ExFlush=0, HazardType=00.
REQ-011 IF_IdFlush SHALL equal ID_Branch and ID_BranchTaken and no stall this cycle; a stall suppresses the flush until the branch resolves in a non-stalled cycle.
REQ-012 Back-to-back: a new hazard detected in the IDLE cycle after HOLD SHALL stall again with no gap.

Reset
REQ-013 While reset=1: state to IDLE, PCWrite=0, IF_IdWrite=0, ID_ExFlush=1, IF_IdFlush=1, HazardType=00.
REQ-014 Reset asserted in HOLD SHALL abort the stall; the first cycle after reset is IDLE.

Configuration
REQ-015 Macro HAZARD_STALL_COUNT_EN, when defined, SHALL add output StallCycles (32 bits).
  - StallCycles increments once per stalled cycle (REQ-008/009) and saturates at 32'hFFFFFFFF.
  - reset clears it to 0.
REQ-016 Without HAZARD_STALL_COUNT_EN, the port and counter SHALL be absent, with no other behavioural change.

Structure
REQ-017 A shared pipeline package SHALL hold the HazardType encodings, the FSM state encodings (IDLE=0, HOLD=1) and the register-zero constant.
REQ-018 One sub-module, hazard_match, SHALL implement Match() (REQ-002); it is instantiated twice, once for ID_Ex_WriteReg and once for Ex_Mem_WriteReg.

Verification
REQ-019 Load-use: ID_Ex_MemRead=1, ID_Ex_WriteReg=8, ID_Rs=8 -> one cycle PCWrite=0, ID_ExFlush=1, HazardType=01; next cycle (ID_Ex_MemRead=0) PCWrite=1.
REQ-020 Branch after load: ID_Branch=1, ID_Ex_MemRead=1, ID_Ex_WriteReg=9, ID_Rt=9, ID_UsesRt=1 -> exactly 2 stall cycles (IDLE->HOLD->IDLE), HazardType=11 both cycles, IF_IdFlush=0 throughout.
REQ-021 Register zero: ID_Ex_MemRead=1, ID_Ex_WriteReg=0, ID_Rs=0 -> no stall, PCWrite=1.
REQ-022 Taken branch, no hazard: ID_Branch=1, ID_BranchTaken=1, ID_Ex_RegWrite=0 -> IF_IdFlush=1, PCWrite=1 same cycle.
REQ-023 Reset in HOLD: start REQ-020, assert reset in the HOLD cycle -> IF_IdFlush=1 and ID_ExFlush=1 during reset; state IDLE after; StallCycles=0 if enabled.
REQ-024 Counter (macro on): three separate load-use hazards plus one 2-cycle branch-load -> StallCycles=5.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// hazard_stall_unit_pkg: shared pipeline encodings for the hazard/stall unit
package hazard_stall_unit_pkg;
  typedef enum logic [1:0] {
    HZ_NONE        = 2'b00,
    HZ_LOAD_USE    = 2'b01,
    HZ_BRANCH_ALU  = 2'b10,
    HZ_BRANCH_LOAD = 2'b11
  } hazard_t;
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/hazard_stall_unit_match.sv
// hazard_match: true when a producer register feeds a source of the IF/ID instruction
module hazard_match
  import hazard_stall_unit_pkg::*;
(
  input  logic [4:0] r,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       uses_rt,
  output logic       match
);
  assign match = (r != REG_ZERO) && ((r == rs) || (uses_rt && (r == rt)));
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: Mealy load-use/branch hazard detection with a one-cycle HOLD extension.
// Define HAZARD_STALL_COUNT_EN to add the saturating StallCycles counter output.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRt,
  input  logic        ID_Branch,
  input  logic        ID_BranchTaken,
  input  logic        ID_Ex_MemRead,
  input  logic        ID_Ex_RegWrite,
  input  logic [4:0]  ID_Ex_WriteReg,
  input  logic        Ex_Mem_MemRead,
  input  logic [4:0]  Ex_Mem_WriteReg,
`ifdef HAZARD_STALL_COUNT_EN
  output logic [31:0] StallCycles,
`endif
  output logic        PCWrite,
  output logic        IF_IdWrite,
  output logic        ID_ExFlush,
  output logic        IF_IdFlush,
  output logic [1:0]  HazardType
);
  logic m_ex, m_mem, bl2, bl1, ba, lu, stall;
  hazard_t det_type, held_type;
  state_t state;
  hazard_match u_match_ex (
    .r(ID_Ex_WriteReg), .rs(ID_Rs), .rt(ID_Rt), .uses_rt(ID_UsesRt), .match(m_ex)
  );
  hazard_match u_match_mem (
    .r(Ex_Mem_WriteReg), .rs(ID_Rs), .rt(ID_Rt), .uses_rt(ID_UsesRt), .match(m_mem)
  );
  always_comb begin
    bl2 = ID_Branch && ID_Ex_MemRead && m_ex;
    bl1 = ID_Branch && Ex_Mem_MemRead && m_mem;
    ba = ID_Branch && ID_Ex_RegWrite && !ID_Ex_MemRead && m_ex;
    lu = ID_Ex_MemRead && m_ex;
    det_type = (bl2 || bl1) ? HZ_BRANCH_LOAD : ba ? HZ_BRANCH_ALU : lu ? HZ_LOAD_USE : HZ_NONE;
    stall = reset || (state == HOLD) || (det_type != HZ_NONE);
    PCWrite = !stall;
    IF_IdWrite = !stall;
    ID_ExFlush = stall;
    IF_IdFlush = reset || (ID_Branch && ID_BranchTaken && !stall);
    HazardType = reset ? HZ_NONE : (state == HOLD) ? held_type : det_type;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      held_type <= HZ_NONE;
    end else if (state == HOLD) begin
      state <= IDLE;
    end else begin
      state <= bl2 ? HOLD : IDLE;
      held_type <= det_type;
    end
  end
`ifdef HAZARD_STALL_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) StallCycles <= '0;
    else if (stall && (StallCycles != '1)) StallCycles <= StallCycles + 32'd1;
  end
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: directed self-checking bench with hand-computed expectations
module tb_hazard_stall_unit;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] ID_Rs, ID_Rt, ID_Ex_WriteReg, Ex_Mem_WriteReg;
  logic ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Ex_MemRead, ID_Ex_RegWrite, Ex_Mem_MemRead;
  logic PCWrite, IF_IdWrite, ID_ExFlush, IF_IdFlush;
  logic [1:0] HazardType;
`ifdef HAZARD_STALL_COUNT_EN
  logic [31:0] StallCycles;
`endif
  int total = 0;
  int bad = 0;
  localparam logic [5:0] RUN      = 6'b110000;
  localparam logic [5:0] RUN_FL   = 6'b110100;
  localparam logic [5:0] IN_RESET = 6'b001100;
  localparam logic [5:0] ST_LU    = 6'b001001;
  localparam logic [5:0] ST_BA    = 6'b001010;
  localparam logic [5:0] ST_BL    = 6'b001011;
  always #5 clk = ~clk;
  hazard_stall_unit dut (
    .clk(clk), .reset(reset),
    .ID_Rs(ID_Rs), .ID_Rt(ID_Rt), .ID_UsesRt(ID_UsesRt),
    .ID_Branch(ID_Branch), .ID_BranchTaken(ID_BranchTaken),
    .ID_Ex_MemRead(ID_Ex_MemRead), .ID_Ex_RegWrite(ID_Ex_RegWrite), .ID_Ex_WriteReg(ID_Ex_WriteReg),
    .Ex_Mem_MemRead(Ex_Mem_MemRead), .Ex_Mem_WriteReg(Ex_Mem_WriteReg),
`ifdef HAZARD_STALL_COUNT_EN
    .StallCycles(StallCycles),
`endif
    .PCWrite(PCWrite), .IF_IdWrite(IF_IdWrite), .ID_ExFlush(ID_ExFlush),
    .IF_IdFlush(IF_IdFlush), .HazardType(HazardType)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clr();
    {ID_Rs, ID_Rt, ID_Ex_WriteReg, Ex_Mem_WriteReg} = '0;
    {ID_UsesRt, ID_Branch, ID_BranchTaken, ID_Ex_MemRead, ID_Ex_RegWrite, Ex_Mem_MemRead} = '0;
  endtask
  task automatic chk(input string tag, input logic [5:0] exp);
    logic [5:0] obs;
    #1;
    obs = {PCWrite, IF_IdWrite, ID_ExFlush, IF_IdFlush, HazardType};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed={pc,ifid,idex,ifflush,ht}=%b expected=%b", tag, obs, exp);
    end
  endtask
`ifdef HAZARD_STALL_COUNT_EN
  task automatic chk_cnt(input string tag, input logic [31:0] exp);
    total++;
    assert (StallCycles === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, StallCycles, exp);
    end
  endtask
`endif
  initial begin
    clr();
    reset = 1'b1;
    tick();
    chk("reset_outputs", IN_RESET);
    tick();
    reset = 1'b0;
    chk("idle_no_hazard", RUN);
`ifdef HAZARD_STALL_COUNT_EN
    chk_cnt("cnt_after_reset", 32'd0);
`endif
    ID_Rs = 5'd8; ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd8;
    chk("load_use_rs", ST_LU);
    tick();
    ID_Ex_MemRead = 1'b0;
    chk("load_use_release", RUN);
    clr();
    ID_Rs = 5'd3; ID_Rt = 5'd8; ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd8;
    chk("rt_unused_no_stall", RUN);
    ID_UsesRt = 1'b1;
    chk("load_use_rt", ST_LU);
    tick();
    clr();
    ID_Ex_MemRead = 1'b1;
    chk("reg_zero_no_stall", RUN);
    clr();
    ID_Branch = 1'b1; ID_BranchTaken = 1'b1;
    chk("taken_branch_flush", RUN_FL);
    ID_Ex_RegWrite = 1'b1; ID_Ex_WriteReg = 5'd5; ID_Rs = 5'd5;
    chk("branch_alu_suppress_flush", ST_BA);
    tick();
    ID_Ex_RegWrite = 1'b0;
    chk("branch_alu_resolved_flush", RUN_FL);
    clr();
    ID_Branch = 1'b1; ID_UsesRt = 1'b1; ID_Rt = 5'd7; Ex_Mem_MemRead = 1'b1; Ex_Mem_WriteReg = 5'd7;
    chk("branch_load_len1", ST_BL);
    tick();
    Ex_Mem_MemRead = 1'b0;
    chk("branch_load_len1_release", RUN);
    clr();
    ID_Branch = 1'b1; ID_Rs = 5'd4; Ex_Mem_MemRead = 1'b1; Ex_Mem_WriteReg = 5'd4;
    ID_UsesRt = 1'b1; ID_Rt = 5'd6; ID_Ex_RegWrite = 1'b1; ID_Ex_WriteReg = 5'd6;
    chk("prio_bl1_over_ba", ST_BL);
    tick();
    clr();
    ID_Branch = 1'b1; ID_BranchTaken = 1'b1; ID_UsesRt = 1'b1; ID_Rt = 5'd9;
    ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd9;
    chk("branch_load_c1", ST_BL);
    tick();
    ID_Branch = 1'b0; ID_Rs = 5'd9;
    chk("branch_load_hold_ignores_inputs", ST_BL);
    tick();
    ID_Branch = 1'b1;
    chk("back_to_back_after_hold", ST_BL);
    tick();
    ID_Ex_MemRead = 1'b0;
    chk("back_to_back_hold", ST_BL);
    tick();
    chk("branch_load_resolved_flush", RUN_FL);
    clr();
    ID_Branch = 1'b1; ID_UsesRt = 1'b1; ID_Rt = 5'd9; ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd9;
    chk("reset_hold_entry", ST_BL);
    tick();
    reset = 1'b1;
    chk("reset_in_hold", IN_RESET);
    tick();
    reset = 1'b0;
    clr();
    chk("idle_after_reset_in_hold", RUN);
`ifdef HAZARD_STALL_COUNT_EN
    chk_cnt("cnt_reset_in_hold", 32'd0);
    for (int i = 0; i < 3; i++) begin
      ID_Rs = 5'd10; ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd10;
      tick();
      clr();
      tick();
    end
    ID_Branch = 1'b1; ID_Rs = 5'd11; ID_Ex_MemRead = 1'b1; ID_Ex_WriteReg = 5'd11;
    tick();
    clr();
    tick();
    tick();
    chk_cnt("cnt_five_stalls", 32'd5);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
